// File: rtl/mobo_bus_arbiter_pkg.sv
// Shared constants for the motherboard bus: arbiter state encodings and
// the mobo_ctrl / mobo_stat bit positions used by the CPU and the board model.
package mobo_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_RELEASE = 2'd2,
    ST_DONE    = 2'd3
  } bus_state_t;

  localparam int unsigned CTRL_REQ_BIT = 0;
  localparam int unsigned CTRL_WE_BIT  = 1;
  localparam int unsigned STAT_ACK_BIT = 0;
  localparam int unsigned TMO_WIDTH    = 16;

  // One-hot round-robin pick; on a tie the port that did not win last time is chosen.
  function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic last_grant);
    logic [1:0] pick;
    pick = '0;
    case (req)
      2'b01:   pick = 2'b01;
      2'b10:   pick = 2'b10;
      2'b11:   pick = last_grant ? 2'b01 : 2'b10;
      default: pick = '0;
    endcase
    return pick;
  endfunction

endpackage

// File: rtl/mobo_bus_arbiter_rr_arbiter_2.sv
// Two-input round-robin grant; last_grant advances only when a grant is issued.
module rr_arbiter_2
  import mobo_bus_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       grant_en,
  output logic [1:0] grant
);

  logic last_grant;

  always_comb begin
    grant = '0;
    if (grant_en) grant = rr_pick(req, last_grant);
  end

  // Reset to port 1 so that port 0 wins the first tie.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant <= 1'b1;
    end else if (|grant) begin
      last_grant <= grant[1];
    end
  end

endmodule

// File: rtl/mobo_bus_arbiter.sv
// Sequences CPU fetch (port 0) and load/store (port 1) requests onto the
// motherboard bus with a four-phase REQ/ACK handshake and a per-phase timeout.
module mobo_bus_arbiter
  import mobo_bus_arbiter_pkg::*;
#(
  parameter int unsigned word_width     = 32,
  parameter int unsigned timeout_cycles = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  input  logic                  req0_we,
  input  logic [word_width-1:0] req0_addr,
  input  logic [word_width-1:0] req0_wdata,
  output logic                  req0_accept,
  output logic                  req0_done,
  input  logic                  req1_valid,
  input  logic                  req1_we,
  input  logic [word_width-1:0] req1_addr,
  input  logic [word_width-1:0] req1_wdata,
  output logic                  req1_accept,
  output logic                  req1_done,
  output logic [word_width-1:0] rdata,
  output logic                  err,
  output logic [word_width-1:0] mobo_ctrl,
  input  logic [word_width-1:0] mobo_stat,
  output logic [word_width-1:0] addr,
  output logic [word_width-1:0] data_out,
  input  logic [word_width-1:0] data_in
);

  localparam logic [TMO_WIDTH-1:0] TMO_LIMIT = TMO_WIDTH'(timeout_cycles);

  bus_state_t            state;
  logic                  gnt_port;
  logic                  we_q;
  logic [TMO_WIDTH-1:0]  tmo_cnt;
  logic [TMO_WIDTH-1:0]  tmo_inc;
  logic                  tmo_hit;
  logic                  ack;
  logic                  stat_unused;
  logic [1:0]            grant;
  logic                  sel_we;
  logic [word_width-1:0] sel_addr;
  logic [word_width-1:0] sel_wdata;
  logic [word_width-1:0] req_word;

  assign ack         = mobo_stat[STAT_ACK_BIT];
  assign stat_unused = ^mobo_stat;
  assign tmo_inc     = tmo_cnt + 1'b1;
  assign tmo_hit     = (tmo_inc == TMO_LIMIT);

  rr_arbiter_2 u_rr (
    .clk      (clk),
    .rst      (rst),
    .req      ({req1_valid, req0_valid}),
    .grant_en (state == ST_IDLE),
    .grant    (grant)
  );

  always_comb begin
    sel_we    = grant[1] ? req1_we    : req0_we;
    sel_addr  = grant[1] ? req1_addr  : req0_addr;
    sel_wdata = grant[1] ? req1_wdata : req0_wdata;
    req_word  = '0;
    req_word[CTRL_REQ_BIT] = 1'b1;
    req_word[CTRL_WE_BIT]  = sel_we;
  end

  // done/err are registered on the edge entering DONE, so they are visible
  // exactly for the single DONE cycle; err then holds until the next DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      gnt_port    <= 1'b0;
      we_q        <= 1'b0;
      tmo_cnt     <= '0;
      mobo_ctrl   <= '0;
      addr        <= '0;
      data_out    <= '0;
      rdata       <= '0;
      err         <= 1'b0;
      req0_accept <= 1'b0;
      req1_accept <= 1'b0;
      req0_done   <= 1'b0;
      req1_done   <= 1'b0;
    end else begin
      req0_accept <= 1'b0;
      req1_accept <= 1'b0;
      req0_done   <= 1'b0;
      req1_done   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (|grant) begin
            gnt_port    <= grant[1];
            we_q        <= sel_we;
            addr        <= sel_addr;
            if (sel_we) data_out <= sel_wdata;
            mobo_ctrl   <= req_word;
            req0_accept <= grant[0];
            req1_accept <= grant[1];
            tmo_cnt     <= '0;
            state       <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (ack) begin
            if (!we_q) rdata <= data_in;
            mobo_ctrl <= '0;
            tmo_cnt   <= '0;
            state     <= ST_RELEASE;
          end else if (tmo_hit) begin
            mobo_ctrl <= '0;
            err       <= 1'b1;
            req0_done <= ~gnt_port;
            req1_done <= gnt_port;
            state     <= ST_DONE;
          end else begin
            tmo_cnt <= tmo_inc;
          end
        end
        ST_RELEASE: begin
          if (!ack) begin
            err       <= 1'b0;
            req0_done <= ~gnt_port;
            req1_done <= gnt_port;
            state     <= ST_DONE;
          end else if (tmo_hit) begin
            err       <= 1'b1;
            req0_done <= ~gnt_port;
            req1_done <= gnt_port;
            state     <= ST_DONE;
          end else begin
            tmo_cnt <= tmo_inc;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
